// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: two writeback requesters (A = ALU,
// B = load) share a single registered write port. Round-robin on contention,
// freeze blocks all grants, writes to the hardwired-zero register are
// accepted but dropped, and a combinational bypass probes the output stage.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              freeze,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  // last_grant_q: 1 = B was granted most recently, 0 = A
  logic              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              grant_a, grant_b, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant decision: a lone requester wins outright; on contention the one
  // not granted last wins. Reset held low and freeze both suppress grants.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset && !freeze) begin
      grant_a = a_valid && (!b_valid || last_grant_q);
      grant_b = b_valid && (!a_valid || !last_grant_q);
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign xfer    = grant_a || grant_b;

  // Next state of the output stage: load the winner, suppress the enable for
  // the zero register, and otherwise hold address/data with the enable low.
  always_comb begin
    sel_addr     = grant_a ? a_addr : b_addr;
    sel_data     = grant_a ? a_data : b_data;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (xfer) begin
      last_grant_d = grant_b;
      wr_en_d      = (sel_addr != ZeroAddr);
      wr_addr_d    = sel_addr;
      wr_data_d    = sel_data;
    end
  end

  // State registers; reset clears the pending write and favours A next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // Bypass looks only at the registered write stage, never at requester inputs.
  always_comb begin
    byp_hit  = wr_en_q && (wr_addr_q == rd_addr);
    byp_data = byp_hit ? wr_data_q : '0;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter. Stimulus checks the combinational
// ready outputs and queues each expected register write tagged with the cycle
// it must appear in; a monitor checks the write port every cycle against it.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, freeze;
  logic [4:0]  a_addr, b_addr, rd_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, wr_en, byp_hit;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, byp_data;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc_cnt = 0;

  regfile_wr_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .freeze(freeze),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Monitor: each falling edge, wr_en must be high exactly when the oldest
  // queued write is due this cycle; then address/data must match it.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check("wr_en", 32'(wr_en), 32'd1);
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", wr_data, e.data);
        $display("write cycle %0d: addr=%0d data=0x%0h", cyc_cnt, wr_addr, wr_data);
      end else begin
        check("wr_en_idle", 32'(wr_en), 32'd0);
      end
    end
  end

  // One cycle of stimulus, entered 1 time unit after a rising edge.
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic fr, input logic exp_ar, input logic exp_br,
                       input logic exp_wr, input logic [4:0] exp_addr,
                       input logic [31:0] exp_data);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    freeze  = fr;
    @(negedge clk);
    check("a_ready", 32'(a_ready), 32'(exp_ar));
    check("b_ready", 32'(b_ready), 32'(exp_br));
    $display("cycle %0d: a_v=%0b b_v=%0b frz=%0b -> a_ready=%0b b_ready=%0b",
             cyc_cnt, av, bv, fr, a_ready, b_ready);
    if (exp_wr) exp_q.push_back('{cyc: cyc_cnt + 1, addr: exp_addr, data: exp_data});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; freeze = 1'b0; rd_addr = 5'd0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    // Held in reset: no grants, cleared output stage, no bypass hit
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_byp_hit", 32'(byp_hit), 32'd0);
    reset = 1'b1;

    // Single A write to r3
    drive(1, 3, 32'h11, 0, 0, 0, 0, 1, 0, 1, 3, 32'h11);
    // Single B write, so the next contention starts with A
    drive(0, 0, 0, 1, 4, 32'h44, 0, 0, 1, 1, 4, 32'h44);
    // Four cycles of contention: A,B,A,B
    drive(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 1, 0, 1, 1, 32'hA1);
    drive(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 1, 1, 2, 32'hB2);
    drive(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 1, 0, 1, 1, 32'hA1);
    drive(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 1, 1, 2, 32'hB2);
    // Write to zero register: accepted, no enable; then contention goes to B
    drive(1, 31, 32'hFF, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 1, 1, 6, 32'h66);
    // Freeze for three cycles, then A (not last granted) wins
    drive(1, 5, 32'h55, 1, 6, 32'h66, 1, 0, 0, 0, 0, 0);
    drive(1, 5, 32'h55, 1, 6, 32'h66, 1, 0, 0, 0, 0, 0);
    drive(1, 5, 32'h55, 1, 6, 32'h66, 1, 0, 0, 0, 0, 0);
    drive(1, 5, 32'h55, 1, 6, 32'h66, 0, 1, 0, 1, 5, 32'h55);
    // Bypass of a pending write to r7
    drive(0, 0, 0, 1, 7, 32'hABCD, 0, 0, 1, 1, 7, 32'hABCD);
    rd_addr = 5'd7;
    #1;
    check("byp_hit_r7", 32'(byp_hit), 32'd1);
    check("byp_data_r7", byp_data, 32'hABCD);
    rd_addr = 5'd8;
    #1;
    check("byp_hit_r8", 32'(byp_hit), 32'd0);
    check("byp_data_r8", byp_data, 32'd0);
    $display("bypass probe: r7 then r8 checked");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Same-address contention on r9: A first, B's value is written last
    drive(1, 9, 32'h1, 1, 9, 32'h2, 0, 1, 0, 1, 9, 32'h1);
    drive(0, 9, 32'h1, 1, 9, 32'h2, 0, 0, 1, 1, 9, 32'h2);
    // Reset between the transfer edge and the next edge drops the write
    drive(1, 10, 32'h77, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("pre_rst_wr_en", 32'(wr_en), 32'd1);
    a_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_wr_en", 32'(wr_en), 32'd0);
    check("async_rst_wr_addr", 32'(wr_addr), 32'd0);
    $display("async reset mid-cycle: wr_en=%0b", wr_en);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // After reset A wins the first contention
    drive(1, 12, 32'hC, 1, 13, 32'hD, 0, 1, 0, 1, 12, 32'hC);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
